arbiter_wrr: RTL and testbench

//  Parametrised weighted round-robin arbiter for a shared resource. Next generation of the single-cycle token arbiter.

---
 rtl/arbiter_wrr_pkg.sv | 38 +++
 rtl/arbiter_wrr_if.sv | 24 ++
 rtl/arbiter_wrr_pick.sv | 23 ++
 rtl/arbiter_wrr.sv | 114 +++++++++++
 tb/tb_arbiter_wrr.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_wrr_pkg.sv
// Shared arbiter package: FSM state encoding and the round-robin search helpers
// used by arbiter_wrr and its pick sub-module.
package arbiter_pkg;

  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Binary index of a one-hot vector (zero for an all-zero vector).
  function automatic int unsigned onehot2bin(input logic [MAX_PORTS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // First set request bit searching from ptr+1 upward with wrap; -1 when none.
  function automatic int rr_find_next(input logic [MAX_PORTS-1:0] req,
                                      input int unsigned ptr,
                                      input int unsigned n);
    int          found;
    int unsigned idx;
    found = -1;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (found < 0 && req[idx]) found = int'(idx);
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/arbiter_wrr_if.sv
// Arbiter request/grant bundle. Macro ARBITER_WRR_LOCK_EN adds the lock input.
interface arbiter_wrr_if #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned WEIGHT_WIDTH = 4
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]              request;
  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [NUM_PORTS-1:0]              grant;
  logic [SEL_WIDTH-1:0]              select;
  logic                              active;
`ifdef ARBITER_WRR_LOCK_EN
  logic                              lock;

  modport slave  (input  request, weight, lock, output grant, select, active);
  modport master (output request, weight, lock, input  grant, select, active);
`else
  modport slave  (input  request, weight, output grant, select, active);
  modport master (output request, weight, input  grant, select, active);
`endif

endinterface

// File: rtl/arbiter_wrr_pick.sv
// Combinational round-robin candidate picker: first request after ptr, with wrap.
module arbiter_wrr_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] cand_c_o,
  output logic                 valid_c_o
);

  int found_c;

  // Rotate-and-priority search delegated to the shared helper.
  always_comb begin
    found_c   = rr_find_next(MAX_PORTS'(req_i), 32'(ptr_i), NUM_PORTS);
    valid_c_o = (found_c >= 0);
    cand_c_o  = valid_c_o ? SEL_WIDTH'(found_c) : '0;
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: holds each grant for up to weight[i] beats.
// Optional macro ARBITER_WRR_LOCK_EN: lock input freezes credit and holds the grant.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  arbiter_wrr_if.slave  bus
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_PORTS);

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [SEL_WIDTH-1:0]    select_q, select_d;
  logic                    active_q, active_d;

  logic [SEL_WIDTH-1:0]    cand_c;
  logic                    cand_valid_c;
  logic [WEIGHT_WIDTH-1:0] cand_weight_c;
  logic                    rearb_c;
  logic                    hold_lock_c;

  arbiter_wrr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req_i     (bus.request),
    .ptr_i     (ptr_q),
    .cand_c_o  (cand_c),
    .valid_c_o (cand_valid_c)
  );

  assign cand_weight_c = bus.weight[int'(cand_c)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

`ifdef ARBITER_WRR_LOCK_EN
  assign hold_lock_c = bus.lock;
`else
  assign hold_lock_c = 1'b0;
`endif

  // State, pointer, credit and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= SEL_WIDTH'(NUM_PORTS - 1);
      credit_q <= '0;
      grant_q  <= '0;
      select_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      active_q <= active_d;
    end
  end

  // Next-state: burst accounting in GRANT, re-arbitration with no idle bubble.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    select_d = select_q;
    active_d = active_q;
    rearb_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rearb_c = cand_valid_c;
      end
      ST_GRANT: begin
        if (!bus.request[ptr_q]) begin
          rearb_c = 1'b1;
        end else if (hold_lock_c) begin
          credit_d = credit_q;
        end else if (credit_q <= WEIGHT_WIDTH'(1)) begin
          rearb_c = 1'b1;
        end else begin
          credit_d = credit_q - WEIGHT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rearb_c) begin
      if (cand_valid_c) begin
        grant_d  = NUM_PORTS'(1) << cand_c;
        select_d = SEL_WIDTH'(onehot2bin(MAX_PORTS'(grant_d)));
        active_d = 1'b1;
        credit_d = (cand_weight_c == '0) ? WEIGHT_WIDTH'(1) : cand_weight_c;
        ptr_d    = cand_c;
        state_d  = ST_GRANT;
      end else begin
        grant_d  = '0;
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  assign bus.grant  = grant_q;
  assign bus.select = select_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr: directed scenarios plus randomized traffic
// compared against a beats-remaining reference model.
module tb_arbiter_wrr;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock_v = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: current owner (-1 idle), last owner, beats left, select.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_left  = 0;
  int m_sel   = 0;

  always #5 clk = ~clk;

  arbiter_wrr_if #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW)) bus ();

`ifdef ARBITER_WRR_LOCK_EN
  assign bus.lock = lock_v;
`endif

  arbiter_wrr #(.NUM_PORTS(N), .WEIGHT_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int find_next(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int weight_of(input int port, input logic [N*WW-1:0] w);
    int v;
    v = int'(w[port*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge();
    logic [N-1:0]    req;
    logic [N*WW-1:0] w;
    int              c;
    bit              reissue;
    req = bus.request;
    w   = bus.weight;
    reissue = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = N - 1; m_left = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      reissue = 1'b1;
    end else if (!req[m_owner]) begin
      reissue = 1'b1;
    end else if (lock_v) begin
      m_left = m_left;
    end else if (m_left == 1) begin
      reissue = 1'b1;
    end else begin
      m_left = m_left - 1;
    end
    if (reissue) begin
      c = find_next(m_ptr, req);
      if (c >= 0) begin
        m_owner = c; m_ptr = c; m_sel = c; m_left = weight_of(c, w);
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    tests_run++;
    assert (bus.grant === eg) else begin
      tests_failed++;
      $error("FAIL %s grant observed=%b expected=%b", tag, bus.grant, eg);
    end
    tests_run++;
    assert (bus.active === (m_owner >= 0)) else begin
      tests_failed++;
      $error("FAIL %s active observed=%b expected=%b", tag, bus.active, (m_owner >= 0));
    end
    tests_run++;
    assert (bus.select === 2'(m_sel)) else begin
      tests_failed++;
      $error("FAIL %s select observed=%0d expected=%0d", tag, bus.select, m_sel);
    end
  endtask

  task automatic expect_grant(input string tag, input logic [N-1:0] exp);
    tests_run++;
    assert (bus.grant === exp) else begin
      tests_failed++;
      $error("FAIL %s grant observed=%b expected=%b", tag, bus.grant, exp);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.request = '0;
    lock_v = 1'b0;
    cycle("reset");
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] t2_owner(input int k);
    int p;
    p = k % 10;
    if (p < 4) return 4'b0001;
    if (p < 7) return 4'b0010;
    if (p < 9) return 4'b0100;
    return 4'b1000;
  endfunction

  initial begin
    bus.request = '0;
    bus.weight  = '0;

    // 1: sole requester regranted every beat
    do_reset();
    bus.weight = 16'h1111;
    bus.request = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cycle("sole");
      expect_grant("sole_hold", 4'b0001);
    end

    // 2: full load, weights 4/3/2/1 for ports 0..3
    do_reset();
    bus.weight = 16'h1234;
    bus.request = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      cycle("wrr");
      expect_grant("wrr_seq", t2_owner(k));
    end

    // 3: owner drops request mid-burst
    do_reset();
    bus.weight = 16'h1050;
    bus.request = 4'b1010;
    for (int i = 0; i < 3; i++) cycle("drop_pre");
    expect_grant("drop_owner", 4'b0010);
    bus.request = 4'b1000;
    cycle("drop");
    expect_grant("drop_move", 4'b1000);
    bus.request = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      cycle("drop_regrant");
      expect_grant("drop_fresh", 4'b0010);
    end
    cycle("drop_rot");
    expect_grant("drop_rot", 4'b1000);

    // 4: weight 0 treated as a single beat
    do_reset();
    bus.weight = 16'h0010;
    bus.request = 4'b0110;
    cycle("w0_a"); expect_grant("w0_a", 4'b0010);
    cycle("w0_b"); expect_grant("w0_b", 4'b0100);
    cycle("w0_c"); expect_grant("w0_c", 4'b0010);

    // 5: reset mid-burst
    do_reset();
    bus.weight = 16'h4444;
    bus.request = 4'b1111;
    cycle("mid_a");
    cycle("mid_b");
    rst = 1'b1;
    cycle("mid_rst");
    expect_grant("mid_rst", 4'b0000);
    rst = 1'b0;
    bus.request = 4'b1100;
    cycle("mid_after");
    expect_grant("mid_after", 4'b0100);

`ifdef ARBITER_WRR_LOCK_EN
    // 6: lock holds an exhausted burst
    do_reset();
    bus.weight = 16'h0001;
    bus.request = 4'b0011;
    lock_v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle("lock");
      expect_grant("lock_hold", 4'b0001);
    end
    lock_v = 1'b0;
    cycle("unlock");
    expect_grant("unlock", 4'b0010);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ((i % 16) == 0) bus.weight = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.request = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
`ifdef ARBITER_WRR_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock_v = ~lock_v;
`endif
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
